// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants: ALU op codes, opcodes/functs, states, operand selects
package mips_pkg;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;
  localparam logic [4:0] ALU_NOR  = 5'd12;
  localparam logic [4:0] ALU_XOR  = 5'd13;
  localparam logic [4:0] ALU_SLLV = 5'd14;
  localparam logic [4:0] ALU_SRAV = 5'd15;
  localparam logic [4:0] ALU_SRLV = 5'd16;
  localparam logic [4:0] ALU_BNE  = 5'd24;
  localparam logic [4:0] ALU_BGTZ = 5'd25;
  localparam logic [4:0] ALU_BLEZ = 5'd26;
  localparam logic [4:0] ALU_BGEZ = 5'd27;
  localparam logic [4:0] ALU_BLTZ = 5'd31;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_BAD
  } iclass_e;

  localparam state_e RESET_STATE = S_FETCH;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller to datapath/memory bus bundle
interface mips_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_waitrequest;
  logic [4:0]  alu_control;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ir_write;
  logic        pc_write;
  logic        pc_write_cond;
  logic        mem_read;
  logic        mem_write;
  logic        addr_sel;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        halted;
  logic [2:0]  state;

  modport master (
    input  instr, alu_zero, mem_waitrequest,
    output alu_control, alu_src_a, alu_src_b, ir_write, pc_write, pc_write_cond,
           mem_read, mem_write, addr_sel, reg_write, reg_dst, mem_to_reg, halted, state
  );

  modport slave (
    output instr, alu_zero, mem_waitrequest,
    input  alu_control, alu_src_a, alu_src_b, ir_write, pc_write, pc_write_cond,
           mem_read, mem_write, addr_sel, reg_write, reg_dst, mem_to_reg, halted, state
  );
endinterface

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational instr to ALU op, operand-B select and instruction class
module alu_op_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  alu_control,
  output logic [1:0]  alu_src_b,
  output iclass_e     iclass
);
  logic [5:0] op, funct;
  logic [4:0] rt;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign rt          = instr[20:16];
  assign funct       = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[15:6]};

  always_comb begin
    alu_control = ALU_ADD;
    alu_src_b   = SRCB_RT;
    iclass      = CLS_BAD;
    case (op)
      OP_RTYPE: begin
        iclass = CLS_R;
        case (funct)
          FN_SLL:  alu_control = ALU_SLL;
          FN_SRL:  alu_control = ALU_SRL;
          FN_SRA:  alu_control = ALU_SRA;
          FN_SLLV: alu_control = ALU_SLLV;
          FN_SRLV: alu_control = ALU_SRLV;
          FN_SRAV: alu_control = ALU_SRAV;
          FN_ADDU: alu_control = ALU_ADD;
          FN_SUBU: alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_XOR:  alu_control = ALU_XOR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SLT:  alu_control = ALU_SLT;
          FN_SLTU: alu_control = ALU_SLTU;
          default: iclass = CLS_BAD;
        endcase
      end
      OP_ADDIU: begin iclass = CLS_I;  alu_control = ALU_ADD;  alu_src_b = SRCB_SEXT; end
      OP_SLTI:  begin iclass = CLS_I;  alu_control = ALU_SLT;  alu_src_b = SRCB_SEXT; end
      OP_SLTIU: begin iclass = CLS_I;  alu_control = ALU_SLTU; alu_src_b = SRCB_SEXT; end
      // Logical immediates take the zero-extended form.
      OP_ANDI:  begin iclass = CLS_I;  alu_control = ALU_AND;  alu_src_b = SRCB_ZEXT; end
      OP_ORI:   begin iclass = CLS_I;  alu_control = ALU_OR;   alu_src_b = SRCB_ZEXT; end
      OP_XORI:  begin iclass = CLS_I;  alu_control = ALU_XOR;  alu_src_b = SRCB_ZEXT; end
      OP_LW:    begin iclass = CLS_LW; alu_control = ALU_ADD;  alu_src_b = SRCB_SEXT; end
      OP_SW:    begin iclass = CLS_SW; alu_control = ALU_ADD;  alu_src_b = SRCB_SEXT; end
      OP_BEQ:   begin iclass = CLS_BR; alu_control = ALU_SUB;  end
      OP_BNE:   begin iclass = CLS_BR; alu_control = ALU_BNE;  end
      OP_BLEZ:  begin iclass = CLS_BR; alu_control = ALU_BLEZ; end
      OP_BGTZ:  begin iclass = CLS_BR; alu_control = ALU_BGTZ; end
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          iclass = CLS_BR; alu_control = ALU_BLTZ;
        end else if (rt == 5'd1) begin
          iclass = CLS_BR; alu_control = ALU_BGEZ;
        end
      end
      default: iclass = CLS_BAD;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM driving ALU, memory bus and datapath enables
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);
  state_e     state_q, state_d;
  logic [4:0] dec_alu;
  logic [1:0] dec_srcb;
  iclass_e    dec_cls;
  logic       fetch_done, mem_done;

  alu_op_decoder u_dec (
    .instr       (bus.instr),
    .alu_control (dec_alu),
    .alu_src_b   (dec_srcb),
    .iclass      (dec_cls)
  );

  // Completion needs the registered request to be up, so the cycle right after
  // reset (requests cleared) never counts as a finished fetch.
  assign fetch_done   = (state_q == S_FETCH) && bus.mem_read && !bus.mem_waitrequest;
  assign mem_done     = (state_q == S_MEM) && (bus.mem_read || bus.mem_write) && !bus.mem_waitrequest;
  assign bus.ir_write = fetch_done;
  assign bus.pc_write = fetch_done;
  assign bus.state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: state_d = (dec_cls == CLS_BAD) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (dec_cls)
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_BR:         state_d = S_FETCH;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem_done) state_d = (dec_cls == CLS_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // Outputs are loaded for the state being entered, so each is a clean register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= RESET_STATE;
      bus.alu_control   <= ALU_ADD;
      bus.alu_src_a     <= 1'b0;
      bus.alu_src_b     <= SRCB_RT;
      bus.pc_write_cond <= 1'b0;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.addr_sel      <= 1'b0;
      bus.reg_write     <= 1'b0;
      bus.reg_dst       <= 1'b0;
      bus.mem_to_reg    <= 1'b0;
      bus.halted        <= 1'b0;
    end else begin
      state_q           <= state_d;
      bus.alu_control   <= ALU_ADD;
      bus.alu_src_a     <= 1'b0;
      bus.alu_src_b     <= SRCB_RT;
      bus.pc_write_cond <= 1'b0;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.addr_sel      <= 1'b0;
      bus.reg_write     <= 1'b0;
      bus.reg_dst       <= 1'b0;
      bus.mem_to_reg    <= 1'b0;
      bus.halted        <= 1'b0;
      case (state_d)
        S_FETCH: begin
          bus.mem_read  <= 1'b1;
          bus.alu_src_b <= SRCB_FOUR;
        end
        S_EXEC: begin
          bus.alu_control   <= dec_alu;
          bus.alu_src_a     <= 1'b1;
          bus.alu_src_b     <= dec_srcb;
          bus.pc_write_cond <= (dec_cls == CLS_BR);
        end
        S_MEM: begin
          bus.addr_sel  <= 1'b1;
          bus.mem_read  <= (dec_cls == CLS_LW);
          bus.mem_write <= (dec_cls == CLS_SW);
        end
        S_WB: begin
          bus.reg_write  <= 1'b1;
          bus.reg_dst    <= (dec_cls == CLS_R);
          bus.mem_to_reg <= (dec_cls == CLS_LW);
        end
        S_HALT:  bus.halted <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for the multicycle control FSM
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] instr;
    logic        wt;
    logic        z;
    logic [2:0]  st;
    logic [4:0]  alu;
    logic [12:0] en;
  } rec_t;

  rec_t sb_q[$];
  int checks = 0;
  int failures = 0;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Packing order: ir_write pc_write pc_write_cond mem_read mem_write addr_sel
  // reg_write reg_dst mem_to_reg halted alu_src_a alu_src_b[1:0]
  function automatic logic [12:0] en(input logic ir, input logic pcw, input logic pcc,
                                     input logic mr, input logic mw, input logic as,
                                     input logic rw, input logic rd, input logic mtr,
                                     input logic h, input logic sa, input logic [1:0] sb);
    return {ir, pcw, pcc, mr, mw, as, rw, rd, mtr, h, sa, sb};
  endfunction

  function automatic logic [12:0] dut_en();
    return {bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write,
            bus.addr_sel, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.halted,
            bus.alu_src_a, bus.alu_src_b};
  endfunction

  task automatic push(input logic [31:0] ins, input logic wt, input logic z,
                      input logic [2:0] st, input logic [4:0] alu, input logic [12:0] e);
    rec_t r;
    r.instr = ins; r.wt = wt; r.z = z; r.st = st; r.alu = alu; r.en = e;
    sb_q.push_back(r);
  endtask

  task automatic push_fetch_decode(input logic [31:0] ins, input int fst);
    for (int k = 0; k <= fst; k++) begin
      logic last;
      last = (k == fst);
      push(ins, !last, 1'b0, 3'd0, 5'd2, en(last, last, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1));
    end
    push(ins, 1'b0, 1'b0, 3'd1, 5'd2, en(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
  endtask

  task automatic push_instr(input logic [31:0] ins, input int cls, input logic [4:0] alu,
                            input logic [1:0] sb, input int fst, input int mst, input logic z);
    push_fetch_decode(ins, fst);
    push(ins, 1'b0, z, 3'd2, alu, en(0, 0, cls == C_BR, 0, 0, 0, 0, 0, 0, 0, 1, sb));
    if (cls == C_LW || cls == C_SW)
      for (int k = 0; k <= mst; k++)
        push(ins, k < mst, 1'b0, 3'd3, 5'd2,
             en(0, 0, 0, cls == C_LW, cls == C_SW, 1, 0, 0, 0, 0, 0, 2'd0));
    if (cls != C_BR && cls != C_SW)
      push(ins, 1'b0, 1'b0, 3'd4, 5'd2,
           en(0, 0, 0, 0, 0, 0, 1, cls == C_R, cls == C_LW, 0, 0, 2'd0));
  endtask

  task automatic drain(input string name);
    rec_t r;
    int cyc;
    cyc = 0;
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      bus.instr = r.instr;
      bus.mem_waitrequest = r.wt;
      bus.alu_zero = r.z;
      @(negedge clk);
      check_eq($sformatf("%s c%0d state", name, cyc), {29'd0, bus.state}, {29'd0, r.st});
      check_eq($sformatf("%s c%0d alu", name, cyc), {27'd0, bus.alu_control}, {27'd0, r.alu});
      check_eq($sformatf("%s c%0d en", name, cyc), {19'd0, dut_en()}, {19'd0, r.en});
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic reset_checks(input string name);
    reset = 1'b1;
    bus.mem_waitrequest = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq({name, " state"}, {29'd0, bus.state}, 32'd0);
    check_eq({name, " mem_read"}, {31'd0, bus.mem_read}, 32'd0);
    check_eq({name, " mem_write"}, {31'd0, bus.mem_write}, 32'd0);
    check_eq({name, " alu"}, {27'd0, bus.alu_control}, 32'd2);
    check_eq({name, " halted"}, {31'd0, bus.halted}, 32'd0);
    check_eq({name, " en"}, {19'd0, dut_en()}, 32'd0);
    reset = 1'b0;
    bus.mem_waitrequest = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.instr = 32'h0;
    bus.alu_zero = 1'b0;
    bus.mem_waitrequest = 1'b1;
    reset_checks("reset0");

    push_instr(32'h00221821, C_R,  5'd2,  2'd0, 0, 0, 1'b0); drain("addu");
    push_instr(32'h8C220004, C_LW, 5'd2,  2'd2, 3, 2, 1'b0); drain("lw_stall");
    push_instr(32'h14220003, C_BR, 5'd24, 2'd0, 0, 0, 1'b1); drain("bne_z1");
    push_instr(32'h14220003, C_BR, 5'd24, 2'd0, 0, 0, 1'b0); drain("bne_z0");
    push_instr(32'h04200002, C_BR, 5'd31, 2'd0, 0, 0, 1'b0); drain("bltz");
    push_instr(32'h04210002, C_BR, 5'd27, 2'd0, 1, 0, 1'b1); drain("bgez");
    push_instr(32'h00221807, C_R,  5'd15, 2'd0, 0, 0, 1'b0); drain("srav");
    push_instr(32'h00021080, C_R,  5'd9,  2'd0, 0, 0, 1'b0); drain("sll");
    push_instr(32'hAC220008, C_SW, 5'd2,  2'd2, 0, 1, 1'b0); drain("sw");
    push_instr(32'h342200FF, C_I,  5'd1,  2'd3, 0, 0, 1'b0); drain("ori");
    push_instr(32'h2422FFFF, C_I,  5'd2,  2'd2, 2, 0, 1'b0); drain("addiu");

    push_fetch_decode(32'hFC000000, 0);
    for (int k = 0; k < 20; k++)
      push(32'hFC000000, k[0], k[1], 3'd7, 5'd2, en(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
    drain("halt");
    reset_checks("reset_halt");

    push_fetch_decode(32'h8C220004, 0);
    push(32'h8C220004, 1'b0, 1'b0, 3'd2, 5'd2, en(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2));
    for (int k = 0; k < 2; k++)
      push(32'h8C220004, 1'b1, 1'b0, 3'd3, 5'd2, en(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0));
    drain("lw_mid");
    reset_checks("reset_mem");

    push_instr(32'h00221823, C_R, 5'd6, 2'd0, 0, 0, 1'b0); drain("subu_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
